// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite OAM DMA, copies CPU page $XX00-$XXFF to OAM_DATA_ADDR after a write to DMA_REG_ADDR
// Ports: CLK/RESET_n (async active-low); CPU_ADDR, CPU_RW_n, CPU_DATA_OUT snoop the CPU for the trigger;
// BUS_DATA_IN is the muxed read data; CPU_HALT/DMA_ACTIVE flag bus ownership; DMA_ADDR, DMA_RW_n,
// DMA_DATA_OUT drive the bus; DMA_DONE pulses once after the final write.
// Optional macro OAM_DMA_ODD_ALIGN_EN adds the ALIGN dummy cycle when the HALT cycle has odd parity.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_RW_n,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic [7:0]  BUS_DATA_IN,
  output logic        CPU_HALT,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RW_n,
  output logic [7:0]  DMA_DATA_OUT,
  output logic        DMA_DONE
);
  typedef enum logic [2:0] {
    IDLE,
    HALT,
`ifdef OAM_DMA_ODD_ALIGN_EN
    ALIGN,
`endif
    READ,
    WRITE
  } state_t;
  state_t state, state_n;
  logic [7:0] page, idx, data_buf;
  logic       par, done;
  logic       trig;
  assign trig = (CPU_ADDR == DMA_REG_ADDR) && !CPU_RW_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = trig ? HALT : IDLE;
`ifdef OAM_DMA_ODD_ALIGN_EN
      HALT:  state_n = par ? ALIGN : READ;
      ALIGN: state_n = READ;
`else
      HALT:  state_n = READ;
`endif
      READ:  state_n = WRITE;
      WRITE: state_n = (idx == 8'hFF) ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= IDLE;
      page     <= '0;
      idx      <= '0;
      data_buf <= '0;
      par      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      par   <= ~par;
      done  <= (state == WRITE) && (idx == 8'hFF);
      if (state == IDLE && trig) begin
        page <= CPU_DATA_OUT;
        idx  <= '0;
      end
      if (state == READ) data_buf <= BUS_DATA_IN;
      if (state == WRITE) idx <= idx + 8'd1;
    end
  end
  assign CPU_HALT     = (state != IDLE);
  assign DMA_ACTIVE   = (state != IDLE);
  assign DMA_ADDR     = (state == READ) ? {page, idx} : (state == WRITE) ? OAM_DATA_ADDR : 16'h0000;
  assign DMA_RW_n     = (state != WRITE);
  assign DMA_DATA_OUT = (state == WRITE) ? data_buf : 8'h00;
  assign DMA_DONE     = done;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;
  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [15:0] CPU_ADDR;
  logic        CPU_RW_n;
  logic [7:0]  CPU_DATA_OUT;
  logic [7:0]  BUS_DATA_IN;
  logic        CPU_HALT, DMA_ACTIVE, DMA_RW_n, DMA_DONE;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA_OUT;
  int checks = 0;
  int errors = 0;
  logic tb_par;
  oam_dma_ctrl dut (
    .CLK(CLK), .RESET_n(RESET_n), .CPU_ADDR(CPU_ADDR), .CPU_RW_n(CPU_RW_n),
    .CPU_DATA_OUT(CPU_DATA_OUT), .BUS_DATA_IN(BUS_DATA_IN), .CPU_HALT(CPU_HALT),
    .DMA_ACTIVE(DMA_ACTIVE), .DMA_ADDR(DMA_ADDR), .DMA_RW_n(DMA_RW_n),
    .DMA_DATA_OUT(DMA_DATA_OUT), .DMA_DONE(DMA_DONE)
  );
  always #5 CLK = ~CLK;
  // source memory: byte at {p,i} is i ^ p ^ 2, so page $02 holds byte i at $0200+i
  assign BUS_DATA_IN = DMA_ADDR[7:0] ^ DMA_ADDR[15:8] ^ 8'h02;
  always @(posedge CLK or negedge RESET_n)
    if (!RESET_n) tb_par <= 1'b0;
    else tb_par <= ~tb_par;
  task automatic bus_idle();
    CPU_ADDR = 16'h0000;
    CPU_RW_n = 1'b1;
    CPU_DATA_OUT = 8'h00;
  endtask
  task automatic test_reset();
    RESET_n = 1'b0;
    bus_idle();
    #1;
    checks++; if (CPU_HALT !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", CPU_HALT); end
    checks++; if (DMA_ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", DMA_ACTIVE); end
    checks++; if (DMA_ADDR !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", DMA_ADDR); end
    checks++; if (DMA_RW_n !== 1'b1) begin errors++; $display("FAIL reset_rw got %b exp 1", DMA_RW_n); end
    checks++; if (DMA_DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", DMA_DATA_OUT); end
    checks++; if (DMA_DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", DMA_DONE); end
    repeat (3) @(negedge CLK);
    RESET_n = 1'b1;
  endtask
  task automatic test_no_trigger();
    logic [15:0] a [3] = '{16'h4015, 16'h2004, 16'h4014};
    logic        r [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      CPU_ADDR = a[k];
      CPU_RW_n = r[k];
      CPU_DATA_OUT = 8'h02;
      @(negedge CLK);
      bus_idle();
      checks++; if (DMA_ACTIVE !== 1'b0) begin errors++; $display("FAIL no_trigger_%0d active got %b exp 0", k, DMA_ACTIVE); end
      @(negedge CLK);
      checks++; if (CPU_HALT !== 1'b0) begin errors++; $display("FAIL no_trigger_%0d halt got %b exp 0", k, CPU_HALT); end
    end
  endtask
  task automatic run_xfer(input logic [7:0] pg, input logic want_odd, input bit retrig, input string nm);
    int cyc = 0, rd = 0, wr = 0, bad_rd = 0, bad_wr = 0, bad_done = 0, first_rd = 0, exp_cyc = 513;
    bit last_rd = 0;
    logic [7:0] eb;
    logic [15:0] last_addr = 16'h0000;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (want_odd) exp_cyc = 514;
`endif
    @(negedge CLK);
    if (tb_par == want_odd) @(negedge CLK);
    CPU_ADDR = 16'h4014;
    CPU_RW_n = 1'b0;
    CPU_DATA_OUT = pg;
    @(negedge CLK);
    bus_idle();
    checks++; if (CPU_HALT !== 1'b1) begin errors++; $display("FAIL %s halt_rise got %b exp 1", nm, CPU_HALT); end
    while (DMA_ACTIVE === 1'b1 && cyc < 600) begin
      cyc++;
      if (DMA_DONE !== 1'b0) bad_done++;
      if (DMA_RW_n === 1'b0) begin
        eb = 8'(wr) ^ pg ^ 8'h02;
        if (DMA_ADDR !== 16'h2004 || DMA_DATA_OUT !== eb || !last_rd) bad_wr++;
        wr++;
        last_rd = 0;
      end else if (DMA_ADDR !== 16'h0000) begin
        if (first_rd == 0) first_rd = cyc;
        if (DMA_ADDR !== {pg, 8'(rd)} || last_rd) bad_rd++;
        last_addr = DMA_ADDR;
        rd++;
        last_rd = 1;
      end
      if (retrig && wr == 10 && DMA_RW_n === 1'b0) begin
        CPU_ADDR = 16'h4014;
        CPU_RW_n = 1'b0;
        CPU_DATA_OUT = 8'h77;
      end
      @(negedge CLK);
      bus_idle();
    end
    checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL %s active_cycles got %0d exp %0d", nm, cyc, exp_cyc); end
    checks++; if (rd != 256) begin errors++; $display("FAIL %s reads got %0d exp 256", nm, rd); end
    checks++; if (wr != 256) begin errors++; $display("FAIL %s writes got %0d exp 256", nm, wr); end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL %s read_seq bad %0d exp 0", nm, bad_rd); end
    checks++; if (bad_wr != 0) begin errors++; $display("FAIL %s write_seq bad %0d exp 0", nm, bad_wr); end
    checks++; if (first_rd != exp_cyc - 511) begin errors++; $display("FAIL %s first_read at T+%0d exp T+%0d", nm, first_rd + 1, exp_cyc - 510); end
    checks++; if (last_addr !== {pg, 8'hFF}) begin errors++; $display("FAIL %s last_read got %h exp %h", nm, last_addr, {pg, 8'hFF}); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL %s early_done got %0d exp 0", nm, bad_done); end
    checks++; if (DMA_DONE !== 1'b1) begin errors++; $display("FAIL %s done_pulse got %b exp 1", nm, DMA_DONE); end
    @(negedge CLK);
    checks++; if (DMA_DONE !== 1'b0) begin errors++; $display("FAIL %s done_width got %b exp 0", nm, DMA_DONE); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    @(negedge CLK);
    CPU_ADDR = 16'h4014;
    CPU_RW_n = 1'b0;
    CPU_DATA_OUT = 8'h03;
    @(negedge CLK);
    bus_idle();
    while (!(DMA_RW_n === 1'b1 && DMA_ADDR === 16'h0364) && n < 400) begin
      n++;
      @(negedge CLK);
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL reset_mid reach_idx100 got timeout exp read of 0364"); end
    RESET_n = 1'b0;
    #1;
    checks++; if (CPU_HALT !== 1'b0) begin errors++; $display("FAIL reset_mid halt got %b exp 0", CPU_HALT); end
    checks++; if (DMA_ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_mid active got %b exp 0", DMA_ACTIVE); end
    checks++; if (DMA_ADDR !== 16'h0000) begin errors++; $display("FAIL reset_mid addr got %h exp 0000", DMA_ADDR); end
    checks++; if (DMA_RW_n !== 1'b1) begin errors++; $display("FAIL reset_mid rw got %b exp 1", DMA_RW_n); end
    checks++; if (DMA_DONE !== 1'b0) begin errors++; $display("FAIL reset_mid done got %b exp 0", DMA_DONE); end
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);
    checks++; if (DMA_DONE !== 1'b0) begin errors++; $display("FAIL reset_mid done_after got %b exp 0", DMA_DONE); end
    run_xfer(8'h02, 1'b1, 0, "after_reset");
  endtask
  initial begin
    test_reset();
    test_no_trigger();
    run_xfer(8'h02, 1'b0, 0, "even_p02");
    run_xfer(8'h02, 1'b1, 0, "odd_p02");
    run_xfer(8'hFF, 1'b0, 0, "page_ff");
    run_xfer(8'h10, 1'b1, 1, "retrigger");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite OAM DMA controller for the CPU bus. A CPU write to $4014 starts a transfer: the block halts the CPU, takes ownership of the CPU address/data bus, and copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAM data port at $2004 as alternating read/write cycles. The block sits beside the CPU on the CPU clock. The top-level bus mux selects DMA address, RW and data whenever DMA_ACTIVE is high, and CPU_ENABLE is gated with ~CPU_HALT.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- CLK  in  1  CPU clock; the only clock.
- RESET_n  in  1  asynchronous, active-low reset.
- CPU_ADDR  in  16  CPU address output.
- CPU_RW_n  in  1  CPU read/write; 1 = read, 0 = write.
- CPU_DATA_OUT  in  8  CPU write data; holds the page number on trigger.
- BUS_DATA_IN  in  8  muxed CPU data bus; read data, valid in the same cycle.
- CPU_HALT  out  1  stalls the CPU while high.
- DMA_ACTIVE  out  1  DMA owns the bus; top-level mux selects DMA_* signals.
- DMA_ADDR  out  16  bus address driven by the DMA.
- DMA_RW_n  out  1  bus direction driven by the DMA.
- DMA_DATA_OUT  out  8  bus write data driven by the DMA.
- DMA_DONE  out  1  one-cycle pulse after the final write.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - page[7:0]: latched source page.
  - idx[7:0]: byte index.
  - buf[7:0]: latched read byte.
  - par: cycle parity; toggles every CLK, 0 out of reset.
- IDLE -> HALT: on the edge ending a cycle where CPU_ADDR==DMA_REG_ADDR and CPU_RW_n==0. On that edge page<=CPU_DATA_OUT and idx<=0.
- HALT: one dummy cycle with no bus access.
  - Next state is ALIGN if alignment is enabled and par==1 during HALT; otherwise READ.
- ALIGN: one dummy cycle, then READ.
- READ:
  - DMA_ADDR={page,idx}, DMA_RW_n=1.
  - buf<=BUS_DATA_IN at the edge ending the cycle; then WRITE.
- WRITE:
  - DMA_ADDR=OAM_DATA_ADDR, DMA_RW_n=0, DMA_DATA_OUT=buf.
  - If idx==8'hFF: go to IDLE and pulse DMA_DONE in the next cycle.
  - Otherwise idx<=idx+1, then READ.
- Address arithmetic is 8-bit on idx only. Page $FF reads $FF00-$FFFF, and the page never increments.
- Triggers in any state other than IDLE are ignored. The CPU is halted in those states, so a retrigger can only come from a testbench.
- Writes to addresses other than DMA_REG_ADDR, and reads of DMA_REG_ADDR, never trigger.
- Bus outputs in IDLE, HALT and ALIGN: DMA_ADDR=16'h0000, DMA_RW_n=1, DMA_DATA_OUT=8'h00.

## Timing
- Reset values: state=IDLE, CPU_HALT=0, DMA_ACTIVE=0, DMA_ADDR=16'h0000, DMA_RW_n=1, DMA_DATA_OUT=8'h00, DMA_DONE=0, idx=0, page=0, buf=0, par=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Cycle T = trigger write cycle.
  - CPU_HALT and DMA_ACTIVE rise at T+1 (HALT state).
  - Both are high for exactly 513 cycles without ALIGN, or 514 with ALIGN.
  - Both fall in the cycle DMA_DONE is high.
- First READ is at T+2, or T+3 with ALIGN.
- READ/WRITE pairs are back-to-back with no gaps: 256 reads and 256 writes.
- Reset asserted mid-transfer: all registers return to reset values immediately (asynchronous). CPU_HALT drops with no DMA_DONE pulse, and OAM contents are left partially written.
- Reset release: the first trigger is accepted on the first full cycle after RESET_n rises.

## Configuration
- Macro: OAM_DMA_ODD_ALIGN_EN.
- Defined: ALIGN state is compiled in; a transfer whose HALT cycle has par==1 takes 514 cycles (hardware-accurate).
- Undefined: ALIGN state and its transition are absent; par is still kept; every transfer takes 513 cycles.

## Test plan
- Trigger at even parity, page $02, source memory filled with byte i at $0200+i → DMA_ACTIVE high for 513 cycles; reads $0200..$02FF in order; each read followed by a write to $2004 with data i; one DMA_DONE pulse.
- OAM_DMA_ODD_ALIGN_EN defined, trigger at odd parity → one ALIGN cycle; 514 active cycles; first READ at T+3. Same stimulus with the macro undefined → 513 cycles.
- Page $FF → last read address is $FFFF; no access to $0000; 256 writes total.
- CPU writes to $4015 and $2004, and a read of $4014 → no trigger; DMA_ACTIVE stays 0.
- Pull RESET_n low during the READ of idx=100 → in the same cycle CPU_HALT=0, DMA_ACTIVE=0, DMA_ADDR=$0000, DMA_RW_n=1; no DMA_DONE. A new trigger after release runs a complete 256-byte transfer starting at idx=0.
- Force a $4014 write while in WRITE state → ignored; transfer completes unchanged with exactly 256 writes.
